ll_fresp_wb_receiver: RTL and testbench

// Receiving end of the long-latency FP response interface (ll_fresp) driven by ALU execute units that contain an IntToFP unit.

---
 rtl/ll_fresp_wb_receiver_if.sv | 37 +++
 rtl/ll_fresp_wb_receiver.sv | 176 +++++++++++++++++
 tb/tb_ll_fresp_wb_receiver.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_fresp_wb_receiver_if.sv
// Long-latency FP response channel (ll_fresp) from IntToFP-capable ALU execute units.
// The master drives a response and its payload; the slave (receiver) returns ready.
interface ll_fresp_wb_receiver_if;
  logic        valid;
  logic        ready;
  logic [19:0] bits_uop_br_mask;
  logic [6:0]  bits_uop_rob_idx;
  logic [6:0]  bits_uop_pdst;
  logic [64:0] bits_data;
  logic        bits_predicated;
  logic        bits_fflags_valid;
  logic [4:0]  bits_fflags_bits_flags;

  modport master (
    output valid,
    output bits_uop_br_mask,
    output bits_uop_rob_idx,
    output bits_uop_pdst,
    output bits_data,
    output bits_predicated,
    output bits_fflags_valid,
    output bits_fflags_bits_flags,
    input  ready
  );

  modport slave (
    input  valid,
    input  bits_uop_br_mask,
    input  bits_uop_rob_idx,
    input  bits_uop_pdst,
    input  bits_data,
    input  bits_predicated,
    input  bits_fflags_valid,
    input  bits_fflags_bits_flags,
    output ready
  );
endinterface

// File: rtl/ll_fresp_wb_receiver.sv
// Buffers ll_fresp responses, applies branch kill/resolve and flush, and writes back in free FP write-port cycles.
// Optional LL_FRESP_WB_PERF_EN adds saturating killed-entry and stall-cycle counters.
module ll_fresp_wb_receiver #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  ll_fresp_wb_receiver_if.slave    io_ll_fresp,
  input  logic [19:0]              io_brupdate_b1_resolve_mask,
  input  logic [19:0]              io_brupdate_b1_mispredict_mask,
  input  logic                     io_flush,
  input  logic                     io_fpu_wb_busy,
  output logic                     io_fpu_stall_req,
  output logic                     io_wb_valid,
  output logic [6:0]               io_wb_pdst,
  output logic [64:0]              io_wb_data,
  output logic                     io_complete_valid,
  output logic [6:0]               io_complete_rob_idx,
  output logic                     io_fflags_valid,
  output logic [4:0]               io_fflags_flags,
  output logic                     io_empty
`ifdef LL_FRESP_WB_PERF_EN
  ,
  output logic [15:0]              io_perf_killed_cnt,
  output logic [15:0]              io_perf_stall_cycles
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CW-1:0] STARVE_MAX = '1;

  logic [DEPTH-1:0] ent_valid;
  logic [19:0]      ent_mask  [DEPTH];
  logic [6:0]       ent_rob   [DEPTH];
  logic [6:0]       ent_pdst  [DEPTH];
  logic [64:0]      ent_data  [DEPTH];
  logic [4:0]       ent_flags [DEPTH];
  logic [DEPTH-1:0] ent_pred;
  logic [DEPTH-1:0] ent_fv;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] count;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          has_head;
  logic          head_kill;
  logic          head_live;
  logic          pop_out;
  logic          pop;
  logic          enq_fire;
  logic          enq;
  logic [CW-1:0] starve;

  // A head being killed this cycle is treated as already dead and retires silently.
  always_comb begin
    count     = tail - head;
    head_idx  = head[AW-1:0];
    tail_idx  = tail[AW-1:0];
    has_head  = (count != '0);
    head_kill = |(ent_mask[head_idx] & io_brupdate_b1_mispredict_mask);
    head_live = has_head & ent_valid[head_idx] & ~head_kill;
    pop_out   = head_live & ~io_fpu_wb_busy & ~io_flush;
    pop       = pop_out | (has_head & ~head_live & ~io_flush);
    enq_fire  = io_ll_fresp.valid & (count != PW'(DEPTH));
    enq       = enq_fire & ~io_flush
              & ~|(io_ll_fresp.bits_uop_br_mask & io_brupdate_b1_mispredict_mask);
  end

  always_comb io_ll_fresp.ready = (count != PW'(DEPTH));

  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      ent_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (|(ent_mask[AW'(i)] & io_brupdate_b1_mispredict_mask)) begin
          ent_valid[AW'(i)] <= 1'b0;
        end else begin
          ent_mask[AW'(i)] <= ent_mask[AW'(i)] & ~io_brupdate_b1_resolve_mask;
        end
      end
      if (pop) begin
        ent_valid[head_idx] <= 1'b0;
      end
      if (enq) begin
        ent_valid[tail_idx] <= 1'b1;
        ent_mask[tail_idx]  <= io_ll_fresp.bits_uop_br_mask & ~io_brupdate_b1_resolve_mask;
        ent_rob[tail_idx]   <= io_ll_fresp.bits_uop_rob_idx;
        ent_pdst[tail_idx]  <= io_ll_fresp.bits_uop_pdst;
        ent_data[tail_idx]  <= io_ll_fresp.bits_data;
        ent_pred[tail_idx]  <= io_ll_fresp.bits_predicated;
        ent_fv[tail_idx]    <= io_ll_fresp.bits_fflags_valid;
        ent_flags[tail_idx] <= io_ll_fresp.bits_fflags_bits_flags;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_wb_valid         <= 1'b0;
      io_complete_valid   <= 1'b0;
      io_fflags_valid     <= 1'b0;
      io_wb_pdst          <= '0;
      io_wb_data          <= '0;
      io_complete_rob_idx <= '0;
      io_fflags_flags     <= '0;
    end else begin
      io_wb_valid       <= pop_out & ~ent_pred[head_idx];
      io_complete_valid <= pop_out;
      io_fflags_valid   <= pop_out & ent_fv[head_idx];
      if (pop_out) begin
        io_wb_pdst          <= ent_pdst[head_idx];
        io_wb_data          <= ent_data[head_idx];
        io_complete_rob_idx <= ent_rob[head_idx];
        io_fflags_flags     <= ent_flags[head_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || io_flush || pop || !has_head) begin
      starve <= '0;
    end else if (head_live && io_fpu_wb_busy && starve != STARVE_MAX) begin
      starve <= starve + CW'(1);
    end
  end

  always_comb begin
    io_fpu_stall_req = (starve >= CW'(STARVE_LIMIT));
    io_empty         = (count == '0) & ~io_wb_valid & ~io_complete_valid;
  end

`ifdef LL_FRESP_WB_PERF_EN
  logic [16:0] killed_sum;

  // Counts stored entries lost to mispredict/flush plus dropped enqueues.
  always_comb begin
    killed_sum = {1'b0, io_perf_killed_cnt};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[AW'(i)] &&
          (io_flush || |(ent_mask[AW'(i)] & io_brupdate_b1_mispredict_mask))) begin
        killed_sum = killed_sum + 17'd1;
      end
    end
    if (enq_fire && !enq) begin
      killed_sum = killed_sum + 17'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      io_perf_killed_cnt   <= '0;
      io_perf_stall_cycles <= '0;
    end else begin
      io_perf_killed_cnt <= killed_sum[16] ? '1 : killed_sum[15:0];
      if (io_fpu_stall_req && io_perf_stall_cycles != '1) begin
        io_perf_stall_cycles <= io_perf_stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ll_fresp_wb_receiver.sv
// Bench for ll_fresp_wb_receiver: a queue-based reference model checked every cycle, plus directed scenarios
// with literal expectations.
module tb_ll_fresp_wb_receiver;
  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] resolve;
  logic [19:0] mispredict;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        wb_valid;
  logic [6:0]  wb_pdst;
  logic [64:0] wb_data;
  logic        complete_valid;
  logic [6:0]  complete_rob;
  logic        fflags_valid;
  logic [4:0]  fflags_flags;
  logic        empty;
`ifdef LL_FRESP_WB_PERF_EN
  logic [15:0] perf_killed;
  logic [15:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ll_fresp_wb_receiver_if lf ();

  ll_fresp_wb_receiver #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock                          (clock),
    .reset                          (reset),
    .io_ll_fresp                    (lf),
    .io_brupdate_b1_resolve_mask    (resolve),
    .io_brupdate_b1_mispredict_mask (mispredict),
    .io_flush                       (flush),
    .io_fpu_wb_busy                 (busy),
    .io_fpu_stall_req               (stall_req),
    .io_wb_valid                    (wb_valid),
    .io_wb_pdst                     (wb_pdst),
    .io_wb_data                     (wb_data),
    .io_complete_valid              (complete_valid),
    .io_complete_rob_idx            (complete_rob),
    .io_fflags_valid                (fflags_valid),
    .io_fflags_flags                (fflags_flags),
    .io_empty                       (empty)
`ifdef LL_FRESP_WB_PERF_EN
    ,
    .io_perf_killed_cnt             (perf_killed),
    .io_perf_stall_cycles           (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of buffered responses in arrival order.
  typedef struct {
    bit          v;
    logic [19:0] mask;
    logic [6:0]  rob;
    logic [6:0]  pdst;
    logic [64:0] data;
    bit          pred;
    bit          fv;
    logic [4:0]  flags;
  } ent_t;

  ent_t        q[$];
  int          m_starve = 0;
  bit          m_wb = 0, m_cv = 0, m_fv = 0;
  logic [6:0]  m_pdst = '0, m_rob = '0;
  logic [64:0] m_data = '0;
  logic [4:0]  m_flags = '0;
  bit          started = 0;

  initial begin
    bit   fire, drop, pop, pop_out;
    ent_t e;
    forever begin
      @(negedge clock);
      if (started) begin
        chk("m_ready",  lf.ready, (q.size() != DEPTH));
        chk("m_wb",     wb_valid, m_wb);
        chk("m_pdst",   wb_pdst, m_pdst);
        chk("m_data",   wb_data, m_data);
        chk("m_cv",     complete_valid, m_cv);
        chk("m_rob",    complete_rob, m_rob);
        chk("m_fv",     fflags_valid, m_fv);
        chk("m_flags",  fflags_flags, m_flags);
        chk("m_stall",  stall_req, (m_starve >= STARVE_LIMIT));
        chk("m_empty",  empty, (q.size() == 0 && !m_wb && !m_cv));
      end
      if (reset) begin
        q.delete();
        m_starve = 0;
        m_wb = 0; m_cv = 0; m_fv = 0;
        m_pdst = '0; m_rob = '0; m_data = '0; m_flags = '0;
        started = 1;
      end else begin
        fire    = lf.valid && (q.size() < DEPTH);
        drop    = flush || ((lf.bits_uop_br_mask & mispredict) != 0);
        pop     = 0;
        pop_out = 0;
        if (q.size() > 0) begin
          if (!q[0].v || (q[0].mask & mispredict) != 0) pop = 1;
          else if (!busy && !flush) begin pop = 1; pop_out = 1; end
        end
        if (flush) begin
          q.delete();
          m_starve = 0;
          m_wb = 0; m_cv = 0; m_fv = 0;
        end else begin
          m_wb = pop_out && !q[0].pred;
          m_cv = pop_out;
          m_fv = pop_out && q[0].fv;
          if (pop_out) begin
            m_pdst  = q[0].pdst;
            m_rob   = q[0].rob;
            m_data  = q[0].data;
            m_flags = q[0].flags;
          end
          if (pop || q.size() == 0) m_starve = 0;
          else if (busy && m_starve < 7) m_starve++;
          foreach (q[i]) begin
            if ((q[i].mask & mispredict) != 0) q[i].v = 0;
            else q[i].mask = q[i].mask & ~resolve;
          end
          if (pop) void'(q.pop_front());
          if (fire && !drop) begin
            e.v     = 1;
            e.mask  = lf.bits_uop_br_mask & ~resolve;
            e.rob   = lf.bits_uop_rob_idx;
            e.pdst  = lf.bits_uop_pdst;
            e.data  = lf.bits_data;
            e.pred  = lf.bits_predicated;
            e.fv    = lf.bits_fflags_valid;
            e.flags = lf.bits_fflags_bits_flags;
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [19:0] m, input logic [6:0] rob, input logic [6:0] pdst,
                       input logic [64:0] d, input logic p, input logic fv, input logic [4:0] fl);
    lf.valid                  = 1'b1;
    lf.bits_uop_br_mask       = m;
    lf.bits_uop_rob_idx       = rob;
    lf.bits_uop_pdst          = pdst;
    lf.bits_data              = d;
    lf.bits_predicated        = p;
    lf.bits_fflags_valid      = fv;
    lf.bits_fflags_bits_flags = fl;
  endtask

  task automatic idle();
    lf.valid = 1'b0;
  endtask

  // Bounded watch: the good ROB index must complete (with given wb_valid), the bad one never.
  task automatic watch(input int cycles, input logic [6:0] good_rob, input logic [6:0] bad_rob,
                       input logic expect_wb, input string name);
    bit seen_good, seen_bad, wb_ok;
    seen_good = 0; seen_bad = 0; wb_ok = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (complete_valid && complete_rob == good_rob) begin
        seen_good = 1;
        wb_ok = (wb_valid == expect_wb);
      end
      if (complete_valid && complete_rob == bad_rob) seen_bad = 1;
    end
    chk({name, "_done"}, seen_good, 1);
    chk({name, "_wb"}, wb_ok, 1);
    chk({name, "_killed"}, seen_bad, 0);
  endtask

  task automatic watch_none(input int cycles, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (complete_valid || wb_valid || fflags_valid) seen = 1;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; flush = 0; busy = 0; resolve = '0; mispredict = '0;
    lf.valid = 0; lf.bits_uop_br_mask = '0; lf.bits_uop_rob_idx = '0; lf.bits_uop_pdst = '0;
    lf.bits_data = '0; lf.bits_predicated = 0; lf.bits_fflags_valid = 0; lf.bits_fflags_bits_flags = '0;
    repeat (3) cyc();
    reset = 0;
    @(negedge clock);
    chk("rst_ready", lf.ready, 1);
    chk("rst_wb", wb_valid, 0);
    chk("rst_cv", complete_valid, 0);
    chk("rst_fv", fflags_valid, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_empty", empty, 1);
    chk("rst_pdst", wb_pdst, 0);
    chk("rst_data", wb_data, 0);

    // Single response, port free
    cyc(); drive(20'h0, 7'h01, 7'h12, 65'h1_3FF0_0000_0000_0000, 0, 0, 5'h0);
    cyc(); idle();
    @(negedge clock);
    chk("t1_lat", wb_valid, 0);
    cyc();
    @(negedge clock);
    chk("t1_wb", wb_valid, 1);
    chk("t1_pdst", wb_pdst, 7'h12);
    chk("t1_data", wb_data, 65'h1_3FF0_0000_0000_0000);
    chk("t1_cv", complete_valid, 1);
    chk("t1_rob", complete_rob, 7'h01);
    cyc();
    @(negedge clock);
    chk("t1_empty", empty, 1);

    // Three back-to-back responses with busy held
    cyc(); busy = 1; drive(20'h0, 7'h10, 7'h20, 65'hA, 0, 0, 5'h0);
    cyc(); drive(20'h0, 7'h11, 7'h21, 65'hB, 0, 0, 5'h0);
    cyc(); drive(20'h0, 7'h12, 7'h22, 65'hC, 0, 0, 5'h0);
    @(negedge clock);
    chk("t2_full", lf.ready, 0);
    cyc(); cyc();
    @(negedge clock);
    chk("t2_stall3", stall_req, 0);
    cyc(); busy = 0;
    @(negedge clock);
    chk("t2_stall4", stall_req, 1);
    cyc();
    @(negedge clock);
    chk("t2_wb_a", wb_valid, 1);
    chk("t2_pdst_a", wb_pdst, 7'h20);
    chk("t2_stall_clr", stall_req, 0);
    cyc(); idle();
    @(negedge clock);
    chk("t2_wb_b", wb_valid, 1);
    chk("t2_pdst_b", wb_pdst, 7'h21);
    repeat (3) cyc();

    // Buffered entry killed by mispredict; a following unmasked entry survives
    cyc(); busy = 1; drive(20'h4, 7'h30, 7'h31, 65'h30, 0, 0, 5'h0);
    cyc(); drive(20'h0, 7'h32, 7'h33, 65'h32, 0, 0, 5'h0); mispredict = 20'h4;
    cyc(); idle(); mispredict = '0; busy = 0;
    watch(6, 7'h32, 7'h30, 1, "t3");

    // Resolve at enqueue clears the bit before a later mispredict
    cyc(); busy = 1; drive(20'h8, 7'h40, 7'h41, 65'h40, 0, 0, 5'h0); resolve = 20'h8;
    cyc(); idle(); resolve = '0; mispredict = 20'h8;
    cyc(); mispredict = '0; busy = 0;
    watch(6, 7'h40, 7'h7F, 1, "t4");

    // Predicated response with flags
    cyc(); drive(20'h0, 7'h50, 7'h51, 65'h50, 1, 1, 5'h01);
    cyc(); idle();
    cyc();
    @(negedge clock);
    chk("t5_wb", wb_valid, 0);
    chk("t5_cv", complete_valid, 1);
    chk("t5_rob", complete_rob, 7'h50);
    chk("t5_fv", fflags_valid, 1);
    chk("t5_flags", fflags_flags, 5'h01);

    // Flush with two buffered entries while port is free
    cyc(); busy = 1; drive(20'h0, 7'h60, 7'h61, 65'h60, 0, 0, 5'h0);
    cyc(); drive(20'h0, 7'h62, 7'h63, 65'h62, 0, 0, 5'h0);
    cyc(); idle(); busy = 0; flush = 1;
    @(negedge clock);
    chk("t6_prefull", lf.ready, 0);
    cyc(); flush = 0;
    @(negedge clock);
    chk("t6_wb", wb_valid, 0);
    chk("t6_cv", complete_valid, 0);
    chk("t6_ready", lf.ready, 1);
    chk("t6_empty", empty, 1);
    watch_none(4, "t6_quiet");

    // Reset mid-stream
    cyc(); drive(20'h0, 7'h70, 7'h71, 65'h70, 0, 1, 5'h3);
    cyc(); drive(20'h0, 7'h72, 7'h73, 65'h72, 0, 0, 5'h0);
    cyc(); idle(); reset = 1;
    @(negedge clock);
    chk("t7_pre_wb", wb_valid, 1);
    cyc(); reset = 0;
    @(negedge clock);
    chk("t7_wb", wb_valid, 0);
    chk("t7_cv", complete_valid, 0);
    chk("t7_fv", fflags_valid, 0);
    chk("t7_empty", empty, 1);
    chk("t7_ready", lf.ready, 1);
    chk("t7_pdst", wb_pdst, 0);
    watch_none(4, "t7_quiet");

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
